// File: rtl/bsg_front_side_bus_hop_out_arb.sv
// Output-side slot scheduler for one front-side-bus ring hop.
// Passthrough ring traffic always owns the outgoing slot. Local words wait in a
// 2-entry buffer and use free slots only. A slot is free when the bus word is
// absent or was consumed at this hop.
//
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   bus_data_i/v_i   incoming ring word from the hop input stage (no flow control)
//   bus_consumed_i   current bus word is taken locally, so its slot is free
//   local_data_i/v_i local injection request
//   local_ready_o    buffer can accept a word (decoded from state only)
//   data_o/v_o       registered outgoing ring word
//   starved_o        local traffic blocked for starve_thresh_p consecutive cycles
module bsg_front_side_bus_hop_out_arb #(
    parameter int unsigned width_p         = 32,
    parameter int unsigned starve_thresh_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] bus_data_i,
    input  logic               bus_v_i,
    input  logic               bus_consumed_i,
    input  logic [width_p-1:0] local_data_i,
    input  logic               local_v_i,
    output logic               local_ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    output logic               starved_o
);

    localparam int unsigned cnt_w_lp = $clog2(starve_thresh_p + 1);

    typedef enum logic [1:0] {
        e_empty = 2'd0,
        e_one   = 2'd1,
        e_full  = 2'd2
    } buf_state_e;

    buf_state_e          state_r;
    logic [width_p-1:0]  head_r;
    logic [width_p-1:0]  second_r;
    logic [width_p-1:0]  data_r;
    logic                v_r;
    logic [cnt_w_lp-1:0] starve_cnt_r;

    logic pass;
    logic nonempty;
    logic enq;
    logic deq;

    // Slot ownership: consume only matters when a bus word is actually present.
    assign pass     = bus_v_i & ~bus_consumed_i;
    assign nonempty = (state_r != e_empty);

    // Ready is a pure state decode so there is no path from local_v_i.
    assign local_ready_o = ~reset_i & (state_r != e_full);
    assign enq           = local_v_i & local_ready_o;
    assign deq           = ~pass & nonempty;

    assign data_o    = data_r;
    assign v_o       = v_r;
    assign starved_o = ~reset_i & (starve_cnt_r == cnt_w_lp'(starve_thresh_p));

    // Output register, local buffer FSM and starve counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_empty;
            data_r       <= '0;
            v_r          <= 1'b0;
            starve_cnt_r <= '0;
        end else begin
            if (pass) begin
                data_r <= bus_data_i;
                v_r    <= 1'b1;
            end else if (nonempty) begin
                data_r <= head_r;
                v_r    <= 1'b1;
            end else begin
                v_r    <= 1'b0;
            end

            // Dequeue decisions use the pre-edge state, so a fresh word is never bypassed.
            unique case (state_r)
                e_empty: begin
                    if (enq) begin
                        head_r  <= local_data_i;
                        state_r <= e_one;
                    end
                end
                e_one: begin
                    if (enq & deq) begin
                        head_r <= local_data_i;
                    end else if (enq) begin
                        second_r <= local_data_i;
                        state_r  <= e_full;
                    end else if (deq) begin
                        state_r <= e_empty;
                    end
                end
                e_full: begin
                    if (deq) begin
                        head_r  <= second_r;
                        state_r <= e_one;
                    end
                end
                default: state_r <= e_empty;
            endcase

            // Counts consecutive cycles a waiting local word lost its slot to passthrough.
            if (deq | ~nonempty) begin
                starve_cnt_r <= '0;
            end else if (starve_cnt_r != cnt_w_lp'(starve_thresh_p)) begin
                starve_cnt_r <= starve_cnt_r + cnt_w_lp'(1);
            end
        end
    end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_arb.sv
// Self-checking bench for bsg_front_side_bus_hop_out_arb: directed scenarios
// followed by a random soak, with a scoreboard of expected outgoing words.
module tb_bsg_front_side_bus_hop_out_arb;

    localparam int unsigned width_lp  = 32;
    localparam int unsigned thresh_lp = 4;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [width_lp-1:0] bus_data_i;
    logic                bus_v_i;
    logic                bus_consumed_i;
    logic [width_lp-1:0] local_data_i;
    logic                local_v_i;
    logic                local_ready_o;
    logic [width_lp-1:0] data_o;
    logic                v_o;
    logic                starved_o;

    bsg_front_side_bus_hop_out_arb #(
        .width_p        (width_lp),
        .starve_thresh_p(thresh_lp)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .bus_data_i    (bus_data_i),
        .bus_v_i       (bus_v_i),
        .bus_consumed_i(bus_consumed_i),
        .local_data_i  (local_data_i),
        .local_v_i     (local_v_i),
        .local_ready_o (local_ready_o),
        .data_o        (data_o),
        .v_o           (v_o),
        .starved_o     (starved_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference state: local buffer contents, expected outgoing words, starve count.
    logic [width_lp-1:0] local_q [$];
    logic [width_lp-1:0] sb_q    [$];
    int unsigned         cnt_m   = 0;
    logic [width_lp-1:0] last_m  = '0;
    logic [width_lp-1:0] bus_tag = 32'h1000_0000;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready/starved, predict, clock, check outputs.
    task automatic step(input logic rst, input logic bv, input logic bc,
                        input logic [width_lp-1:0] bd, input logic lv,
                        input logic [width_lp-1:0] ld);
        logic exp_rdy, exp_v, pass, nonempty, deq;
        logic [width_lp-1:0] w;
        reset_i        = rst;
        bus_v_i        = bv;
        bus_consumed_i = bc;
        bus_data_i     = bd;
        local_v_i      = lv;
        local_data_i   = ld;
        #1;
        exp_rdy = !rst && (local_q.size() < 2);
        chk("local_ready", 32'(local_ready_o), 32'(exp_rdy));
        chk("starved_pre", 32'(starved_o), 32'(!rst && cnt_m == thresh_lp));
        exp_v = 1'b0;
        if (rst) begin
            local_q.delete();
            sb_q.delete();
            cnt_m  = 0;
            last_m = '0;
        end else begin
            pass     = bv && !bc;
            nonempty = local_q.size() > 0;
            deq      = !pass && nonempty;
            if (pass) begin
                exp_v = 1'b1;
                sb_q.push_back(bd);
            end else if (nonempty) begin
                exp_v = 1'b1;
                sb_q.push_back(local_q.pop_front());
            end
            if (lv && exp_rdy) local_q.push_back(ld);
            if (deq || !nonempty) cnt_m = 0;
            else if (cnt_m < thresh_lp) cnt_m++;
        end
        @(posedge clk_i);
        #1;
        chk("v_o", 32'(v_o), 32'(exp_v));
        if (v_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                w = sb_q.pop_front();
                chk("data_o", data_o, w);
                last_m = w;
            end
        end else begin
            chk("data_hold", data_o, last_m);
        end
        chk("starved", 32'(starved_o), 32'(!rst && cnt_m == thresh_lp));
    endtask

    // Passthrough bus cycle with a unique tagged word.
    task automatic bus_cycle(input logic lv, input logic [width_lp-1:0] ld);
        bus_tag++;
        step(1'b0, 1'b1, 1'b0, bus_tag, lv, ld);
    endtask

    initial begin
        // Reset held with traffic present: nothing accepted or emitted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 1'b1, 32'hBAD0_0001);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Passthrough priority over a waiting local word.
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hA5A5_A5A5);
        step(1'b0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'h2222_2222, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Consumed slot reused by local head; the consumed word never appears.
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0007);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Fill under saturated bus, free one slot, then enq+deq in ONE.
        for (int i = 0; i < 4; i++) bus_cycle(1'b1, 32'hC000_0000 + 32'(i));
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        bus_cycle(1'b1, 32'hC000_0010);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hC000_0020);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hC000_0021);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Starvation: one waiting word, bus saturated past threshold, then released.
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h5555_0001);
        for (int i = 0; i < 6; i++) bus_cycle(1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Reset mid-operation drops buffered words.
        bus_cycle(1'b1, 32'h7777_0001);
        bus_cycle(1'b1, 32'h7777_0002);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Random soak across bus loads.
        for (int load = 0; load <= 100; load += 25) begin
            for (int i = 0; i < 400; i++) begin
                logic bv, bc, lv;
                bv = ($urandom_range(0, 99) < load);
                bc = ($urandom_range(0, 3) == 0);
                lv = ($urandom_range(0, 1) == 1);
                bus_tag++;
                step(1'b0, bv, bc, bus_tag, lv, $urandom);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        chk("buf_drained", 32'(local_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
